// File: rtl/mac_ctrl_pkg.sv
// Shared types and sizing helpers for the MAC array sequencer.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Time counter must reach K_max + ROWS + COLS - 2 without wrapping.
  function automatic int unsigned ctr_width(input int unsigned k_width,
                                            input int unsigned rows,
                                            input int unsigned cols);
    return k_width + $clog2(rows + cols) + 1;
  endfunction

endpackage

// File: rtl/mac_ena_gen.sv
// Skewed per-PE enable windows: PE(r,c) is active for K cycles starting at t = 1+r+c.
module mac_ena_gen
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned K_WIDTH = 8,
  parameter int unsigned T_WIDTH = ctr_width(K_WIDTH, ROWS, COLS)
) (
  input  logic [T_WIDTH-1:0]   i_t,
  input  logic [K_WIDTH-1:0]   i_k,
  input  logic                 i_in_feed,
  output logic [ROWS*COLS-1:0] o_mac_ena
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam logic [T_WIDTH-1:0] LO = T_WIDTH'(1 + r + c);
      logic [T_WIDTH-1:0] w_hi;
      assign w_hi = LO + T_WIDTH'(i_k);
      assign o_mac_ena[r*COLS+c] = i_in_feed && (i_t >= LO) && (i_t < w_hi);
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for an output-stationary MAC array: clear, feed with skew, drain rows.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter  int unsigned ROWS    = 4,
  parameter  int unsigned COLS    = 4,
  parameter  int unsigned K_WIDTH = 8,
  localparam int unsigned RD_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_WIDTH-1:0]   k_len,
  output logic                 busy,
  output logic                 mac_clear,
  output logic                 fetch_en,
  output logic [K_WIDTH-1:0]   fetch_k,
  output logic [ROWS*COLS-1:0] mac_ena,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [RD_W-1:0]      rd_row,
  output logic                 done
);

  localparam int unsigned T_WIDTH = ctr_width(K_WIDTH, ROWS, COLS);

  state_e             r_state;
  logic [K_WIDTH-1:0] r_k;
  logic [T_WIDTH-1:0] r_t;
  logic               r_busy;
  logic               r_mac_clear;
  logic               r_fetch_en;
  logic [K_WIDTH-1:0] r_fetch_k;
  logic               r_rd_valid;
  logic [RD_W-1:0]    r_rd_row;
  logic               r_done;

  logic [T_WIDTH-1:0] w_t_inc;
  logic [T_WIDTH-1:0] w_k_ext;
  logic [T_WIDTH-1:0] w_t_last;
  logic               w_rd_last;
  logic               w_in_feed;

  assign w_t_inc   = r_t + T_WIDTH'(1);
  assign w_k_ext   = T_WIDTH'(r_k);
  // Last enable of the far-corner PE; FEED ends after this cycle.
  assign w_t_last  = w_k_ext + T_WIDTH'(ROWS + COLS - 2);
  assign w_rd_last = (r_rd_row == RD_W'(ROWS - 1));
  assign w_in_feed = (r_state == FEED);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_t         <= '0;
      r_busy      <= 1'b0;
      r_mac_clear <= 1'b0;
      r_fetch_en  <= 1'b0;
      r_fetch_k   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_row    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_mac_clear <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k         <= k_len;
            r_state     <= CLEAR;
            r_busy      <= 1'b1;
            r_mac_clear <= 1'b1;
          end
        end
        CLEAR: begin
          r_t <= '0;
          if (r_k != '0) begin
            r_state    <= FEED;
            r_fetch_en <= 1'b1;
            r_fetch_k  <= '0;
          end else begin
            r_state    <= DRAIN;
            r_rd_valid <= 1'b1;
            r_rd_row   <= '0;
          end
        end
        FEED: begin
          if (r_t == w_t_last) begin
            r_state    <= DRAIN;
            r_t        <= '0;
            r_fetch_en <= 1'b0;
            r_fetch_k  <= '0;
            r_rd_valid <= 1'b1;
            r_rd_row   <= '0;
          end else begin
            r_t <= w_t_inc;
            if (w_t_inc < w_k_ext) begin
              r_fetch_en <= 1'b1;
              r_fetch_k  <= K_WIDTH'(w_t_inc);
            end else begin
              r_fetch_en <= 1'b0;
              r_fetch_k  <= '0;
            end
          end
        end
        DRAIN: begin
          if (rd_ready) begin
            if (w_rd_last) begin
              r_state    <= IDLE;
              r_rd_valid <= 1'b0;
              r_rd_row   <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_rd_row <= r_rd_row + RD_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mac_ena_gen #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .K_WIDTH (K_WIDTH),
    .T_WIDTH (T_WIDTH)
  ) u_ena_gen (
    .i_t       (r_t),
    .i_k       (r_k),
    .i_in_feed (w_in_feed),
    .o_mac_ena (mac_ena)
  );

  assign busy      = r_busy;
  assign mac_clear = r_mac_clear;
  assign fetch_en  = r_fetch_en;
  assign fetch_k   = r_fetch_k;
  assign rd_valid  = r_rd_valid;
  assign rd_row    = r_rd_row;
  assign done      = r_done;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: stimulus queues expected events, monitor pops and compares.
module tb_mac_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [KW-1:0]  k_len;
  logic           busy;
  logic           mac_clear;
  logic           fetch_en;
  logic [KW-1:0]  fetch_k;
  logic [15:0]    mac_ena;
  logic           rd_valid;
  logic           rd_ready;
  logic [1:0]     rd_row;
  logic           done;

  mac_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .mac_clear (mac_clear),
    .fetch_en  (fetch_en),
    .fetch_k   (fetch_k),
    .mac_ena   (mac_ena),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_row    (rd_row),
    .done      (done)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t clr_q[$];
  ev_t fet_q[$];
  ev_t ena_q[$];
  ev_t rd_q[$];
  ev_t stl_q[$];
  ev_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_on = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_ev(input string name, input int ac, input int ec, input int av, input int ev);
    checks++;
    if (ac != ec || av != ev) begin
      errors++;
      $display("FAIL %s: got cycle %0d value 0x%0h, required cycle %0d value 0x%0h", name, ac, av, ec, ev);
    end
  endtask

  task automatic chk_val(input string name, input int av, input int ev);
    checks++;
    if (av != ev) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, av, ev);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d, none required", name, cyc);
  endtask

  function automatic int ena_exp(input int t, input int k);
    int v = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (t >= 1 + r + c && t < 1 + r + c + k) v |= (1 << (r * COLS + c));
    return v;
  endfunction

  // Monitor: every visible DUT event must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (mac_clear) begin
        if (clr_q.size() == 0) unexp("clear");
        else begin e = clr_q.pop_front(); chk_ev("clear", cyc, e.cyc, int'(busy), 1); end
      end
      if (fetch_en) begin
        if (fet_q.size() == 0) unexp("fetch");
        else begin e = fet_q.pop_front(); chk_ev("fetch", cyc, e.cyc, int'(fetch_k), e.val); end
      end else if (fetch_k != 0) chk_val("fetch_k_idle", int'(fetch_k), 0);
      if (mac_ena != 0) begin
        if (ena_q.size() == 0) unexp("mac_ena");
        else begin e = ena_q.pop_front(); chk_ev("mac_ena", cyc, e.cyc, int'(mac_ena), e.val); end
      end
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) unexp("rd");
        else begin e = rd_q.pop_front(); chk_ev("rd", cyc, e.cyc, int'(rd_row), e.val); end
      end else if (rd_valid) begin
        if (stl_q.size() == 0) unexp("rd_stall");
        else begin e = stl_q.pop_front(); chk_ev("rd_stall", cyc, e.cyc, int'(rd_row), e.val); end
      end else if (rd_row != 0) chk_val("rd_row_idle", int'(rd_row), 0);
      if (done) begin
        if (done_q.size() == 0) unexp("done");
        else begin e = done_q.pop_front(); chk_ev("done", cyc, e.cyc, int'(busy), 0); end
      end
    end
  end

  // Issue a job in the current cycle and return in its done cycle.
  task automatic run_job(input int k, input int stall, input int ghost);
    int s, d, dn;
    s = cyc;
    start = 1'b1;
    k_len = KW'(k);
    d  = s + 2 + ((k > 0) ? (k + ROWS + COLS - 1) : 0);
    dn = d + ROWS + stall;
    clr_q.push_back('{s + 1, 0});
    for (int i = 0; i < k; i++) fet_q.push_back('{s + 2 + i, i});
    if (k > 0)
      for (int t = 0; t <= k + ROWS + COLS - 2; t++)
        if (ena_exp(t, k) != 0) ena_q.push_back('{s + 2 + t, ena_exp(t, k)});
    for (int j = 0; j < ROWS; j++)
      rd_q.push_back('{(j < 2) ? d + j : d + j + stall, j});
    for (int i = 0; i < stall; i++) stl_q.push_back('{d + 2 + i, 2});
    done_q.push_back('{dn, 0});
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 8'hA5;
    while (cyc < dn) begin
      if (ghost > 0 && cyc == s + ghost) begin
        start = 1'b1;
        k_len = 8'd9;
      end else begin
        start = 1'b0;
        k_len = 8'hA5;
      end
      rd_ready = !(stall > 0 && cyc >= d + 2 && cyc < d + 2 + stall);
      @(posedge clk); #1;
    end
    start    = 1'b0;
    rd_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_busy"}, int'(busy), 0);
    chk_val({tag, "_mac_clear"}, int'(mac_clear), 0);
    chk_val({tag, "_fetch_en"}, int'(fetch_en), 0);
    chk_val({tag, "_fetch_k"}, int'(fetch_k), 0);
    chk_val({tag, "_mac_ena"}, int'(mac_ena), 0);
    chk_val({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk_val({tag, "_rd_row"}, int'(rd_row), 0);
    chk_val({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int s;
    reset    = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    mon_on = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    run_job(3, 0, 0);
    idle(3);
    run_job(0, 0, 0);
    idle(2);
    run_job(3, 5, 0);
    idle(2);
    run_job(3, 0, 5);
    idle(2);

    // Abort mid-FEED at t=4, then a clean K=2 job.
    s = cyc;
    start = 1'b1;
    k_len = 8'd3;
    clr_q.push_back('{s + 1, 0});
    for (int i = 0; i < 3; i++) fet_q.push_back('{s + 2 + i, i});
    for (int t = 1; t <= 4; t++) ena_q.push_back('{s + 2 + t, ena_exp(t, 3)});
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(2, 0, 0);
    idle(2);

    // Back-to-back jobs with different K.
    run_job(3, 0, 0);
    run_job(5, 0, 0);
    run_job(1, 0, 0);
    idle(3);

    chk_val("clr_q_left", clr_q.size(), 0);
    chk_val("fet_q_left", fet_q.size(), 0);
    chk_val("ena_q_left", ena_q.size(), 0);
    chk_val("rd_q_left", rd_q.size(), 0);
    chk_val("stl_q_left", stl_q.size(), 0);
    chk_val("done_q_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
